// File: rtl/microcode_sequencer.sv
// Control-store sequencer: boots microcode ROM into RAM, then sequences microwords
// with jump/call/return/stall/halt. Optional parity check: MICROSEQ_PARITY_CHECK_EN.
module microcode_sequencer #(
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    WORD_WIDTH  = 64,
  parameter int                    STACK_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] HALT_ADDR   = 8'hFE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_WIDTH-1:0] rom_data,
  output logic [ADDR_WIDTH-1:0] cs_addr,
  output logic                  cs_we,
  output logic [WORD_WIDTH-1:0] cs_wdata,
  output logic                  cs_ready,
  input  logic                  stall,
  input  logic                  jump,
  input  logic                  jump_src,
  input  logic [ADDR_WIDTH-1:0] jump_imm,
  input  logic [ADDR_WIDTH-1:0] ir,
  input  logic                  cond_en,
  input  logic                  cond,
  input  logic                  call,
  input  logic                  ret,
  output logic                  halted,
  output logic                  stack_err
`ifdef MICROSEQ_PARITY_CHECK_EN
  ,
  input  logic [WORD_WIDTH-1:0] cs_rdata,
  output logic                  parity_err
`endif
);

  localparam int                SP_W    = $clog2(STACK_DEPTH + 1);
  localparam logic [SP_W-1:0]   SP_FULL = SP_W'(STACK_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_t;

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   addr_n, addr_inc, target;
  logic [SP_W-1:0]         sp, sp_n;
  logic                    err_n;
  logic                    push_en;
  logic [ADDR_WIDTH-1:0]   stack_mem [2**SP_W];
`ifdef MICROSEQ_PARITY_CHECK_EN
  logic                    perr_n;
`endif

  assign addr_inc = cs_addr + ADDR_WIDTH'(1);
  assign target   = jump_src ? jump_imm : ir;
  assign cs_wdata = rom_data;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_n = state;
    addr_n  = cs_addr;
    sp_n    = sp;
    err_n   = stack_err;
    push_en = 1'b0;
    cs_we   = 1'b0;
`ifdef MICROSEQ_PARITY_CHECK_EN
    perr_n  = parity_err;
`endif
    unique case (state)
      ST_BOOT: begin
        cs_we  = 1'b1;
        addr_n = addr_inc;
        if (cs_addr == ADDR_MAX) state_n = ST_RUN;
      end
      ST_RUN: begin
        if (!stall) begin
          // A bad-parity word halts before any other decision; X counts as bad.
`ifdef MICROSEQ_PARITY_CHECK_EN
          if ((^cs_rdata) !== 1'b1) begin
            state_n = ST_HALT;
            perr_n  = 1'b1;
          end else
`endif
          if (cs_addr == HALT_ADDR) begin
            state_n = ST_HALT;
          end else if (ret) begin
            if (sp != '0) begin
              addr_n = stack_mem[sp - SP_W'(1)];
              sp_n   = sp - SP_W'(1);
            end else begin
              err_n  = 1'b1;
              addr_n = addr_inc;
            end
          end else if (call) begin
            if (sp < SP_FULL) begin
              push_en = 1'b1;
              sp_n    = sp + SP_W'(1);
            end else begin
              err_n = 1'b1;
            end
            addr_n = target;
          end else if (jump && (!cond_en || cond)) begin
            addr_n = target;
          end else begin
            addr_n = addr_inc;
          end
        end
      end
      default: ;  // ST_HALT: frozen until reset
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      state     <= ST_BOOT;
      cs_addr   <= '0;
      sp        <= '0;
      cs_ready  <= 1'b0;
      halted    <= 1'b0;
      stack_err <= 1'b0;
    end else begin
      state     <= state_n;
      cs_addr   <= addr_n;
      sp        <= sp_n;
      cs_ready  <= (state_n != ST_BOOT);
      halted    <= (state_n == ST_HALT);
      stack_err <= err_n;
    end
  end

`ifdef MICROSEQ_PARITY_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) parity_err <= 1'b0;
    else       parity_err <= perr_n;
  end
`endif

  // NOTE: stack storage is deliberately not reset; sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push_en) stack_mem[sp] <= addr_inc;
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench for microcode_sequencer: directed scenarios plus randomized RUN
// traffic against a queue-based behavioural model.
module tb_microcode_sequencer;

  localparam int DEPTH  = 256;
  localparam int HALT_A = 'hFE;
  localparam int SD     = 4;
  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic        clk = 1'b0;
  logic        reset, stall, jump, jump_src, cond_en, cond, call, ret;
  logic [7:0]  jump_imm, ir, cs_addr;
  logic [63:0] rom_data, cs_wdata, cs_rdata;
  logic        cs_we, cs_ready, halted, stack_err;
`ifdef MICROSEQ_PARITY_CHECK_EN
  logic        parity_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  int m_mode;
  int m_addr;
  int m_stack[$];
  bit m_err;
  bit m_perr;

  microcode_sequencer dut (
    .clk(clk), .reset(reset), .rom_data(rom_data), .cs_addr(cs_addr), .cs_we(cs_we),
    .cs_wdata(cs_wdata), .cs_ready(cs_ready), .stall(stall), .jump(jump),
    .jump_src(jump_src), .jump_imm(jump_imm), .ir(ir), .cond_en(cond_en), .cond(cond),
    .call(call), .ret(ret), .halted(halted), .stack_err(stack_err)
`ifdef MICROSEQ_PARITY_CHECK_EN
    , .cs_rdata(cs_rdata), .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_update();
    int tgt;
    tgt = jump_src ? int'(jump_imm) : int'(ir);
    if (reset) begin
      m_mode = M_BOOT; m_addr = 0; m_stack.delete(); m_err = 0; m_perr = 0;
      return;
    end
    case (m_mode)
      M_BOOT: begin
        if (m_addr == DEPTH - 1) m_mode = M_RUN;
        m_addr = (m_addr + 1) % DEPTH;
      end
      M_RUN: if (!stall) begin
`ifdef MICROSEQ_PARITY_CHECK_EN
        if ((^cs_rdata) !== 1'b1) begin m_mode = M_HALT; m_perr = 1; return; end
`endif
        if (m_addr == HALT_A) m_mode = M_HALT;
        else if (ret) begin
          if (m_stack.size() > 0) m_addr = m_stack.pop_back();
          else begin m_err = 1; m_addr = (m_addr + 1) % DEPTH; end
        end else if (call) begin
          if (m_stack.size() < SD) m_stack.push_back((m_addr + 1) % DEPTH);
          else m_err = 1;
          m_addr = tgt;
        end else if (jump && (!cond_en || cond)) m_addr = tgt;
        else m_addr = (m_addr + 1) % DEPTH;
      end
      default: ;
    endcase
  endtask

  task automatic cycle();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    stall = 0; jump = 0; jump_src = 0; jump_imm = 0; ir = 0;
    cond_en = 0; cond = 0; call = 0; ret = 0;
  endtask

  task automatic goto_addr(input logic [7:0] a);
    jump = 1; jump_src = 1; jump_imm = a;
    cycle();
    clear_ctrl();
  endtask

  task automatic reset_boot();
    clear_ctrl();
    reset = 1; cycle(); reset = 0;
    repeat (DEPTH) cycle();
  endtask

  task automatic test_reset();
    reset = 1; stall = 1; jump = 1; call = 1; ret = 1;
    cycle(); cycle();
    clear_ctrl();
    n_checks++; if (cs_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h want 00", cs_addr); end
    n_checks++; if (cs_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", cs_ready); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
    n_checks++; if (stack_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", stack_err); end
    n_checks++; if (cs_we !== 1'b1) begin n_fail++; $display("FAIL reset_we: got %b want 1", cs_we); end
  endtask

  task automatic test_boot();
    logic [7:0] e;
    reset = 0;
    for (int i = 0; i < DEPTH; i++) begin
      e = 8'(i);
      rom_data = {$urandom, $urandom};
      stall = 1'($urandom); jump = 1'($urandom); call = 1'($urandom); ret = 1'($urandom);
      jump_src = 1; jump_imm = 8'($urandom);
      #1;
      n_checks++; if (cs_we !== 1'b1) begin n_fail++; $display("FAIL boot_we[%0d]: got %b want 1", i, cs_we); end
      n_checks++; if (cs_addr !== e) begin n_fail++; $display("FAIL boot_addr[%0d]: got %h want %h", i, cs_addr, e); end
      n_checks++; if (cs_wdata !== rom_data) begin n_fail++; $display("FAIL boot_wdata[%0d]: got %h want %h", i, cs_wdata, rom_data); end
      n_checks++; if (cs_ready !== 1'b0) begin n_fail++; $display("FAIL boot_ready[%0d]: got %b want 0", i, cs_ready); end
      cycle();
    end
    clear_ctrl();
    n_checks++; if (cs_ready !== 1'b1) begin n_fail++; $display("FAIL boot_done_ready: got %b want 1", cs_ready); end
    n_checks++; if (cs_addr !== 8'h00) begin n_fail++; $display("FAIL boot_done_addr: got %h want 00", cs_addr); end
    n_checks++; if (cs_we !== 1'b0) begin n_fail++; $display("FAIL boot_done_we: got %b want 0", cs_we); end
  endtask

  task automatic test_jump();
    goto_addr(8'h10);
    n_checks++; if (cs_addr !== 8'h10) begin n_fail++; $display("FAIL jump_setup: got %h want 10", cs_addr); end
    jump = 1; jump_src = 1; jump_imm = 8'h40; cycle(); clear_ctrl();
    n_checks++; if (cs_addr !== 8'h40) begin n_fail++; $display("FAIL jump_imm: got %h want 40", cs_addr); end
    goto_addr(8'h10);
    jump = 1; jump_src = 1; jump_imm = 8'h40; cond_en = 1; cond = 0; cycle();
    n_checks++; if (cs_addr !== 8'h11) begin n_fail++; $display("FAIL jump_cond_false: got %h want 11", cs_addr); end
    cond = 1; cycle(); clear_ctrl();
    n_checks++; if (cs_addr !== 8'h40) begin n_fail++; $display("FAIL jump_cond_true: got %h want 40", cs_addr); end
    jump = 1; jump_src = 0; ir = 8'hA3; jump_imm = 8'h40; cycle(); clear_ctrl();
    n_checks++; if (cs_addr !== 8'hA3) begin n_fail++; $display("FAIL jump_ir: got %h want A3", cs_addr); end
  endtask

  task automatic test_call_ret();
    goto_addr(8'h20);
    call = 1; jump_src = 1; jump_imm = 8'h50; cycle(); clear_ctrl();
    n_checks++; if (cs_addr !== 8'h50) begin n_fail++; $display("FAIL call1: got %h want 50", cs_addr); end
    cycle();
    n_checks++; if (cs_addr !== 8'h51) begin n_fail++; $display("FAIL call_step: got %h want 51", cs_addr); end
    call = 1; jump_src = 1; jump_imm = 8'h60; cycle(); clear_ctrl();
    n_checks++; if (cs_addr !== 8'h60) begin n_fail++; $display("FAIL call2: got %h want 60", cs_addr); end
    ret = 1; cycle();
    n_checks++; if (cs_addr !== 8'h52) begin n_fail++; $display("FAIL ret1: got %h want 52", cs_addr); end
    cycle(); clear_ctrl();
    n_checks++; if (cs_addr !== 8'h21) begin n_fail++; $display("FAIL ret2: got %h want 21", cs_addr); end
    n_checks++; if (stack_err !== 1'b0) begin n_fail++; $display("FAIL call_ret_err: got %b want 0", stack_err); end
  endtask

  task automatic test_overflow();
    logic [7:0] t;
    goto_addr(8'h30);
    for (int k = 0; k < 5; k++) begin
      t = 8'(8'h70 + 4 * k);
      call = 1; jump_src = 1; jump_imm = t; cond_en = 1; cond = 0;
      cycle();
      n_checks++; if (cs_addr !== t) begin n_fail++; $display("FAIL ovf_call[%0d]: got %h want %h", k, cs_addr, t); end
      n_checks++; if (stack_err !== (k == 4)) begin n_fail++; $display("FAIL ovf_err[%0d]: got %b want %b", k, stack_err, k == 4); end
    end
    clear_ctrl();
    // pops with call also asserted: ret wins, the final one underflows
    for (int k = 0; k < 5; k++) begin
      ret = 1; call = 1; jump_src = 1; jump_imm = 8'hEE;
      cycle();
      n_checks++; if (cs_addr !== 8'(m_addr)) begin n_fail++; $display("FAIL ovf_ret[%0d]: got %h want %h", k, cs_addr, 8'(m_addr)); end
    end
    clear_ctrl();
    n_checks++; if (cs_addr !== 8'h32) begin n_fail++; $display("FAIL underflow_addr: got %h want 32", cs_addr); end
    n_checks++; if (stack_err !== 1'b1) begin n_fail++; $display("FAIL underflow_err: got %b want 1", stack_err); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      stall    = ($urandom % 5) == 0;
      ret      = ($urandom % 4) == 0;
      call     = ($urandom % 4) == 0;
      jump     = 1'($urandom);
      jump_src = 1'($urandom);
      cond_en  = 1'($urandom);
      cond     = 1'($urandom);
      jump_imm = 8'($urandom);
      ir       = 8'($urandom);
      cycle();
      n_checks++; if (cs_addr !== 8'(m_addr)) begin n_fail++; $display("FAIL rand_addr[%0d]: got %h want %h", i, cs_addr, 8'(m_addr)); end
      n_checks++; if (stack_err !== m_err) begin n_fail++; $display("FAIL rand_err[%0d]: got %b want %b", i, stack_err, m_err); end
      n_checks++; if (halted !== (m_mode == M_HALT)) begin n_fail++; $display("FAIL rand_halted[%0d]: got %b want %b", i, halted, m_mode == M_HALT); end
    end
    clear_ctrl();
  endtask

  task automatic test_halt();
    logic [7:0] e;
    reset_boot();
    goto_addr(8'hFD);
    cycle();
    n_checks++; if (cs_addr !== 8'hFE) begin n_fail++; $display("FAIL halt_reach: got %h want FE", cs_addr); end
    for (int k = 0; k < 3; k++) begin
      stall = 1; jump = 1; jump_src = 1; jump_imm = 8'h40;
      cycle();
      n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_stalled[%0d]: got %b want 0", k, halted); end
      n_checks++; if (cs_addr !== 8'hFE) begin n_fail++; $display("FAIL halt_stall_addr[%0d]: got %h want FE", k, cs_addr); end
    end
    stall = 0; jump = 1; call = 1; jump_src = 1; jump_imm = 8'h40;
    cycle();
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_enter: got %b want 1", halted); end
    n_checks++; if (cs_addr !== 8'hFE) begin n_fail++; $display("FAIL halt_addr: got %h want FE", cs_addr); end
    for (int k = 0; k < 5; k++) begin
      stall = 1'($urandom); jump = 1; call = 1'($urandom); ret = 1'($urandom);
      jump_imm = 8'($urandom); ir = 8'($urandom);
      cycle();
      n_checks++; if (cs_addr !== 8'hFE || halted !== 1'b1) begin
        n_fail++; $display("FAIL halt_frozen[%0d]: got addr %h halted %b want FE 1", k, cs_addr, halted);
      end
    end
    n_checks++; if (cs_ready !== 1'b1) begin n_fail++; $display("FAIL halt_ready: got %b want 1", cs_ready); end
    clear_ctrl();
    reset = 1; cycle(); reset = 0;
    n_checks++; if (cs_addr !== 8'h00 || halted !== 1'b0 || cs_ready !== 1'b0) begin
      n_fail++; $display("FAIL halt_reset: got addr %h halted %b ready %b want 00 0 0", cs_addr, halted, cs_ready);
    end
    for (int k = 1; k <= 3; k++) begin
      e = 8'(k);
      cycle();
      n_checks++; if (cs_addr !== e || cs_we !== 1'b1) begin
        n_fail++; $display("FAIL reboot[%0d]: got addr %h we %b want %h 1", k, cs_addr, cs_we, e);
      end
    end
  endtask

`ifdef MICROSEQ_PARITY_CHECK_EN
  task automatic test_parity();
    cs_rdata = 64'h0;  // even parity during BOOT must be ignored
    reset_boot();
    cs_rdata = 64'h1;
    n_checks++; if (halted !== 1'b0 || parity_err !== 1'b0) begin
      n_fail++; $display("FAIL parity_boot: got halted %b perr %b want 0 0", halted, parity_err);
    end
    goto_addr(8'h33);
    n_checks++; if (cs_addr !== 8'h33) begin n_fail++; $display("FAIL parity_setup: got %h want 33", cs_addr); end
    cs_rdata = 64'h3;
    cycle();
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL parity_halted: got %b want 1", halted); end
    n_checks++; if (parity_err !== 1'b1) begin n_fail++; $display("FAIL parity_err: got %b want 1", parity_err); end
    n_checks++; if (cs_addr !== 8'h33) begin n_fail++; $display("FAIL parity_addr: got %h want 33", cs_addr); end
    cs_rdata = 64'h1;
  endtask
`endif

  initial begin
    clear_ctrl();
    reset = 1; rom_data = '0; cs_rdata = 64'h1;
    m_mode = M_BOOT; m_addr = 0; m_err = 0; m_perr = 0;
    test_reset();
    test_boot();
    test_jump();
    test_call_ret();
    test_overflow();
    test_random();
    test_halt();
`ifdef MICROSEQ_PARITY_CHECK_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
